// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU micro-sequencer: FSM state codes, instruction layout, ALUOp codes.
// No logic; latency and backpressure not applicable.
// Field positions mirror the packed instr_t layout for software/assembler use.
package alu_seq_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_EXEC  = 2'd2;
  localparam state_t ST_HALT  = 2'd3;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       src1;
    logic       src2;
    logic       wr;
    logic       br;
    logic       halt;
    logic [5:0] target;
    logic [7:0] imm8;
  } instr_t;

  localparam int OP_LSB     = 28;
  localparam int RD_LSB     = 25;
  localparam int RS1_LSB    = 22;
  localparam int RS2_LSB    = 19;
  localparam int SRC1_BIT   = 18;
  localparam int SRC2_BIT   = 17;
  localparam int WR_BIT     = 16;
  localparam int BR_BIT     = 15;
  localparam int HALT_BIT   = 14;
  localparam int TARGET_LSB = 8;
  localparam int IMM_LSB    = 0;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;
  localparam logic [3:0] ALU_NOR = 4'hC;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: sync-write, sync-read RAM without reset.
// Read data valid one cycle after re; no backpressure.
// Writes are gated by the caller; no internal arbitration.
module seq_prog_mem #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/alu_sequencer.sv
// Stored-program micro-sequencer driving the reg_file/mux/alu datapath.
// Two cycles per instruction (FETCH, EXEC); taken branches cost nothing extra.
// No backpressure: the datapath result is consumed combinationally in EXEC.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int PC_W    = 6,
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_ovf,
  input  logic               alu_take_branch,
  output logic [3:0]         alu_op,
  output logic               alu_src1,
  output logic               alu_src2,
  output logic [DATA_W-1:0]  alu_imm,
  output logic               reg_write,
  output logic [2:0]         rd0_addr,
  output logic [2:0]         rd1_addr,
  output logic [2:0]         wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy,
  output logic               done,
  output logic [PC_W-1:0]    pc,
  output logic [15:0]        instr_count,
  output logic               ovf_sticky
);

  state_t             state;
  logic [INSTR_W-1:0] mem_rdata;
  instr_t             ir;
  logic               in_exec;
  logic               loadable;
  logic               mem_we;
  logic               mem_re;

  assign loadable = (state == ST_IDLE) || (state == ST_HALT);
  assign mem_we   = prog_we && loadable && !reset;
  assign mem_re   = (state == ST_FETCH);

  seq_prog_mem #(
    .ADDR_W (PC_W),
    .DATA_W (INSTR_W)
  ) u_prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (mem_re),
    .raddr (pc),
    .rdata (mem_rdata)
  );

  // The RAM read register acts as IR; masking it outside EXEC gives the
  // all-zero IR/control view without needing a resettable RAM output.
  assign in_exec = (state == ST_EXEC) && !reset;
  assign ir      = in_exec ? instr_t'(mem_rdata) : '0;

  assign alu_op    = ir.op;
  assign alu_src1  = ir.src1;
  assign alu_src2  = ir.src2;
  assign alu_imm   = {{(DATA_W-8){ir.imm8[7]}}, ir.imm8};
  assign reg_write = ir.wr;
  assign rd0_addr  = ir.rs1;
  assign rd1_addr  = ir.rs2;
  assign wr_addr   = ir.rd;
  assign wr_data   = in_exec ? alu_result : '0;
  assign busy      = (state == ST_FETCH) || (state == ST_EXEC);
  assign done      = (state == ST_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= '0;
      instr_count <= '0;
      ovf_sticky  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state       <= ST_FETCH;
            pc          <= '0;
            instr_count <= '0;
            ovf_sticky  <= 1'b0;
          end
        end
        ST_FETCH: state <= ST_EXEC;
        ST_EXEC: begin
          instr_count <= instr_count + 16'd1;
          if (ir.wr && alu_ovf) ovf_sticky <= 1'b1;
          // halt takes priority over a simultaneous taken branch
          if (ir.halt) begin
            state <= ST_HALT;
          end else begin
            state <= ST_FETCH;
            pc    <= (ir.br && alu_take_branch) ? PC_W'(ir.target) : pc + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
